// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_ctrl_pkg : states, command opcodes and operand addresses shared  |
// |                by the sys_ctrl command sequencer                     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADDR   = 4'd1,
    WR_DATA   = 4'd2,
    RD_ADDR   = 4'd3,
    RD_WAIT   = 4'd4,
    OP_A      = 4'd5,
    OP_B      = 4'd6,
    ALU_FUN   = 4'd7,
    ALU_WAIT  = 4'd8,
    TX_LO     = 4'd9,
    TX_HI     = 4'd10,
    TX_RD     = 4'd11
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // States that sit inside a frame waiting for the next command byte.
  function automatic logic is_byte_wait(input state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == OP_A)    || (s == OP_B)    || (s == ALU_FUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_ctrl_if : UART rx/tx, register-file and ALU bus of sys_ctrl      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic                    rx_err;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic                    alu_en;
  logic [FUN_WIDTH-1:0]    alu_fun;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_valid;
  logic                    clk_gate_en;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (
    input  rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid,
           alu_out, alu_out_valid, tx_ready,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid,
           alu_out, alu_out_valid, tx_ready,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/sys_ctrl_tx_ser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_ctrl_tx_ser : holds a 1- or 2-byte response and presents it      |
// |                   LSB first on a valid/ready byte handshake          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module sys_ctrl_tx_ser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    two_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  input  logic                    ready_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  output logic                    accept_o
);
  logic                  valid_q;
  logic                  hi_pend_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] hi_q;

  assign accept_o = valid_q & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      hi_pend_q <= 1'b0;
      data_q    <= '0;
      hi_q      <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      hi_pend_q <= two_i;
      data_q    <= data_i[DATA_WIDTH-1:0];
      hi_q      <= data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    end else if (accept_o) begin
      // Second byte goes out the cycle after the first is taken.
      if (hi_pend_q) begin
        data_q    <= hi_q;
        hi_pend_q <= 1'b0;
      end else begin
        valid_q   <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule
`default_nettype wire

// File: rtl/sys_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_ctrl : UART command sequencer driving the register file and ALU  |
// |            Optional inter-byte timeout: SYS_CTRL_TIMEOUT_EN          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  sys_ctrl_if.master bus_if
);
  state_e                  state_q, state_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    gate_q, gate_d;
  logic                    alu_pend_q, alu_pend_d;
  logic                    tx_load, tx_two, tx_accept;
  logic [2*DATA_WIDTH-1:0] tx_load_data;
  logic                    timeout_hit;
  logic                    rx_ok, rx_bad;

  assign rx_ok  = bus_if.rx_valid & ~bus_if.rx_err;
  assign rx_bad = bus_if.rx_valid &  bus_if.rx_err;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (is_byte_wait(state_q) && !bus_if.rx_valid) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
      else                                     to_cnt_d    = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  // Always 0 for any legal TIMEOUT_CYC; the limit only matters with the counter built.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    gate_d       = gate_q;
    alu_pend_d   = alu_pend_q;
    tx_load      = 1'b0;
    tx_two       = 1'b0;
    tx_load_data = '0;
    case (state_q)
      IDLE: if (rx_ok) begin
        if      (bus_if.rx_data == DATA_WIDTH'(CMD_WR))      state_d = WR_ADDR;
        else if (bus_if.rx_data == DATA_WIDTH'(CMD_RD))      state_d = RD_ADDR;
        else if (bus_if.rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = OP_A;
        else if (bus_if.rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN;
      end
      WR_ADDR: if (rx_ok) begin
        rf_addr_d = bus_if.rx_data[ADDR_WIDTH-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (rx_ok) begin
        rf_wr_data_d = bus_if.rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR: if (rx_ok) begin
        rf_addr_d  = bus_if.rx_data[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (bus_if.rf_rd_valid) begin
        tx_load      = 1'b1;
        tx_load_data = {{DATA_WIDTH{1'b0}}, bus_if.rf_rd_data};
        state_d      = TX_RD;
      end
      OP_A: if (rx_ok) begin
        rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
        rf_wr_data_d = bus_if.rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = OP_B;
      end
      OP_B: if (rx_ok) begin
        rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
        rf_wr_data_d = bus_if.rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_FUN;
      end
      ALU_FUN: if (rx_ok) begin
        alu_fun_d  = bus_if.rx_data[FUN_WIDTH-1:0];
        gate_d     = 1'b1;
        alu_pend_d = 1'b1;
        state_d    = ALU_WAIT;
      end
      ALU_WAIT: begin
        // One cycle of gated clock before the strobe lets the ALU clock settle.
        if (alu_pend_q) begin
          alu_en_d   = 1'b1;
          alu_pend_d = 1'b0;
        end else if (bus_if.alu_out_valid) begin
          gate_d       = 1'b0;
          tx_load      = 1'b1;
          tx_two       = 1'b1;
          tx_load_data = bus_if.alu_out;
          state_d      = TX_LO;
        end
      end
      TX_LO:   if (tx_accept) state_d = TX_HI;
      TX_HI:   if (tx_accept) state_d = IDLE;
      TX_RD:   if (tx_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((rx_bad && is_byte_wait(state_q)) || timeout_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_fun_q    <= '0;
      gate_q       <= 1'b0;
      alu_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_fun_q    <= alu_fun_d;
      gate_q       <= gate_d;
      alu_pend_q   <= alu_pend_d;
    end
  end

  sys_ctrl_tx_ser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tx_load),
    .two_i    (tx_two),
    .data_i   (tx_load_data),
    .ready_i  (bus_if.tx_ready),
    .data_o   (bus_if.tx_data),
    .valid_o  (bus_if.tx_valid),
    .accept_o (tx_accept)
  );

  assign bus_if.rf_wr_en    = rf_wr_en_q;
  assign bus_if.rf_rd_en    = rf_rd_en_q;
  assign bus_if.alu_en      = alu_en_q;
  assign bus_if.rf_addr     = rf_addr_q;
  assign bus_if.rf_wr_data  = rf_wr_data_q;
  assign bus_if.alu_fun     = alu_fun_q;
  assign bus_if.clk_gate_en = gate_q;
endmodule
`default_nettype wire
